// File: rtl/m1_reset_gen_pkg.sv
// Milkymist system reset generator: shared defaults and output bundle.
// Imported by the generator RTL and its bench.
package m1_reset_gen_pkg;

  localparam int unsigned RST_CYCLES_DEF       = 1048575;
  localparam int unsigned FLASH_RST_CYCLES_DEF = 255;

  typedef struct packed {
    logic sys_rst;
    logic flash_rst_n;
    logic ac97_rst_n;
    logic videoin_rst_n;
  } rst_out_t;

endpackage

// File: rtl/m1_reset_gen_if.sv
// Reset fan-out bundle between the generator and its consumers.
// master = generator side, slave = reset consumers / requesters.
interface m1_reset_gen_if;

  logic trigger_reset;
  logic sys_rst;
  logic flash_rst_n;
  logic ac97_rst_n;
  logic videoin_rst_n;

  modport master (
    input  trigger_reset,
    output sys_rst,
    output flash_rst_n,
    output ac97_rst_n,
    output videoin_rst_n
  );

  modport slave (
    output trigger_reset,
    input  sys_rst,
    input  flash_rst_n,
    input  ac97_rst_n,
    input  videoin_rst_n
  );

endinterface

// File: rtl/m1_rst_sync.sv
// Two-flop reset synchronizer: asynchronous assert,
// release on the second rising edge after ext_rst_n rises.
module m1_rst_sync (
  input  logic sys_clk,
  input  logic ext_rst_n,
  output logic rst_sync_n
);

  logic ff1_d, ff1_q;
  logic ff2_d, ff2_q;

  // shift a constant one through the chain
  always_comb begin
    ff1_d = 1'b1;
    ff2_d = ff1_q;
  end

  // both flops cleared at once by the board reset
  always_ff @(posedge sys_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign rst_sync_n = ff2_q;

endmodule

// File: rtl/m1_reset_gen.sv
// Milkymist system reset generator: stretches board and
// software resets; flash leaves reset before the CPU.
module m1_reset_gen
  import m1_reset_gen_pkg::*;
#(
  parameter int unsigned RST_CYCLES       = RST_CYCLES_DEF,
  parameter int unsigned FLASH_RST_CYCLES = FLASH_RST_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic ext_rst_n,
  input  logic trigger_reset,
  output logic sys_rst,
  output logic flash_rst_n,
  output logic ac97_rst_n,
  output logic videoin_rst_n
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int FW = $clog2(FLASH_RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES);
  localparam logic [FW-1:0] FL_LOAD  = FW'(FLASH_RST_CYCLES);

  logic rst_sync_n;

  logic [RW-1:0] rst_cnt_d, rst_cnt_q;
  logic [FW-1:0] flash_cnt_d, flash_cnt_q;
  logic sys_rst_d, sys_rst_q;
  logic flash_n_d, flash_n_q;
  logic per_n_d, per_n_q;

  m1_rst_sync u_sync (
    .sys_clk    (sys_clk),
    .ext_rst_n  (ext_rst_n),
    .rst_sync_n (rst_sync_n)
  );

  // reload on request, otherwise count down and park at zero
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    flash_cnt_d = flash_cnt_q;
    if (trigger_reset) begin
      rst_cnt_d   = RST_LOAD;
      flash_cnt_d = FL_LOAD;
    end else begin
      if (rst_cnt_q != '0)
        rst_cnt_d = rst_cnt_q - RW'(1);
      if (flash_cnt_q != '0)
        flash_cnt_d = flash_cnt_q - FW'(1);
    end
    sys_rst_d = (rst_cnt_d != '0);
    flash_n_d = (flash_cnt_d == '0);
    per_n_d   = (rst_cnt_d == '0);
  end

  // counters and glitch-free output registers
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rst_cnt_q   <= RST_LOAD;
      flash_cnt_q <= FL_LOAD;
      sys_rst_q   <= 1'b1;
      flash_n_q   <= 1'b0;
      per_n_q     <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      sys_rst_q   <= sys_rst_d;
      flash_n_q   <= flash_n_d;
      per_n_q     <= per_n_d;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign flash_rst_n   = flash_n_q;
  assign ac97_rst_n    = per_n_q;
  assign videoin_rst_n = per_n_q;

endmodule

// File: tb/tb_m1_reset_gen.sv
// Bench for m1_reset_gen: per-edge expected outputs derived
// from the release timeline, queued then checked after each edge.
module tb_m1_reset_gen;
  import m1_reset_gen_pkg::*;

  localparam int unsigned RC = 16;
  localparam int unsigned FC = 4;

  logic clk = 1'b0;
  logic ext_rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  rst_out_t exp_q[$];

  m1_reset_gen_if rif ();

  m1_reset_gen #(
    .RST_CYCLES       (RC),
    .FLASH_RST_CYCLES (FC)
  ) dut (
    .sys_clk       (clk),
    .ext_rst_n     (ext_rst_n),
    .trigger_reset (rif.trigger_reset),
    .sys_rst       (rif.sys_rst),
    .flash_rst_n   (rif.flash_rst_n),
    .ac97_rst_n    (rif.ac97_rst_n),
    .videoin_rst_n (rif.videoin_rst_n)
  );

  always #5 clk = ~clk;

  function automatic rst_out_t mk(input logic s, input logic f);
    rst_out_t v;
    v.sys_rst       = s;
    v.flash_rst_n   = f;
    v.ac97_rst_n    = ~s;
    v.videoin_rst_n = ~s;
    return v;
  endfunction

  function automatic rst_out_t got();
    rst_out_t v;
    v.sys_rst       = rif.sys_rst;
    v.flash_rst_n   = rif.flash_rst_n;
    v.ac97_rst_n    = rif.ac97_rst_n;
    v.videoin_rst_n = rif.videoin_rst_n;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k = edges since release; counting starts at edge 3
  task automatic release_seq(input string nm);
    rst_out_t g, w;
    ext_rst_n = 1'b1;
    for (int k = 1; k <= RC + 4; k++) begin
      exp_q.push_back(mk(k < RC + 2, k >= FC + 2));
      tick();
      g = got();
      w = exp_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL %s edge=%0d got=%b want=%b", nm, k, g, w);
      end
    end
  endtask

  task automatic test_reset();
    rst_out_t g, w;
    ext_rst_n = 1'b0;
    rif.trigger_reset = 1'b0;
    #2;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(1'b1, 1'b0));
      tick();
      g = got();
      w = exp_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got=%b want=%b", k, g, w);
      end
    end
    release_seq("power_on");
  endtask

  task automatic test_idle(input int n);
    rst_out_t g, w;
    rif.trigger_reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mk(1'b0, 1'b1));
      tick();
      g = got();
      w = exp_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL idle k=%0d got=%b want=%b", k, g, w);
      end
    end
  endtask

  // trigger high on edges [0,hold) and on edge re (if re>=0)
  task automatic test_trigger(input string nm, input int hold,
                              input int re, input int len);
    rst_out_t g, w;
    int last;
    last = -1;
    for (int k = 0; k < len; k++) begin
      rif.trigger_reset = (k < hold) || (k == re);
      if (rif.trigger_reset) last = k;
      exp_q.push_back(mk((k - last) < RC, (k - last) >= FC));
      tick();
      g = got();
      w = exp_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL %s k=%0d got=%b want=%b", nm, k, g, w);
      end
    end
    rif.trigger_reset = 1'b0;
  endtask

  task automatic test_async_abort();
    rst_out_t g, w;
    test_trigger("abort_pre", 1, -1, 8);
    #2;
    ext_rst_n = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0));
    #1;
    g = got();
    w = exp_q.pop_front();
    n_cmp++;
    if (g !== w) begin
      n_err++;
      $display("FAIL abort_immediate got=%b want=%b", g, w);
    end
    rif.trigger_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b1, 1'b0));
      tick();
      g = got();
      w = exp_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL abort_hold k=%0d got=%b want=%b", k, g, w);
      end
    end
    rif.trigger_reset = 1'b0;
    release_seq("abort_replay");
  endtask

  task automatic test_trigger_in_sync();
    ext_rst_n = 1'b0;
    #1;
    tick();
    tick();
    ext_rst_n = 1'b1;
    rif.trigger_reset = 1'b1;
    tick();
    rif.trigger_reset = 1'b0;
    begin
      rst_out_t g, w;
      for (int k = 2; k <= RC + 4; k++) begin
        exp_q.push_back(mk(k < RC + 2, k >= FC + 2));
        tick();
        g = got();
        w = exp_q.pop_front();
        n_cmp++;
        if (g !== w) begin
          n_err++;
          $display("FAIL trig_in_sync edge=%0d got=%b want=%b", k, g, w);
        end
      end
    end
  endtask

  initial begin
    rif.trigger_reset = 1'b0;
    test_reset();
    test_idle(4);
    test_trigger("sw_trigger", 1, -1, RC + 6);
    test_idle(3);
    test_trigger("retrigger", 1, 10, RC + 16);
    test_idle(3);
    test_trigger("held", 40, -1, 40 + RC + 6);
    test_idle(3);
    test_async_abort();
    test_idle(3);
    test_trigger_in_sync();
    test_idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
